nibble_serial_add_ctrl: RTL
===========================

// Module: nibble_serial_add_ctrl
// PURPOSE
//  Sequencer that performs a 4*NIBBLES-bit add through the existing combinational 4-bit adder
//  (ports Cin, A[3:0], B[3:0] -> S[3:0], C[4:1]). It is upstream and downstream of that adder.
//  It drives the adder one nibble per cycle, LSB nibble first, and chains each carry to the next nibble.
//  It collects S into a wide result. Start/busy/done handshake toward the host logic.
// PARAMETERS
//  NIBBLES  4  number of 4-bit slices; operand width OPW = 4*NIBBLES (16 by default)
// PORTS
//  clk       in   1      system clock, rising edge
//  rst_n     in   1      asynchronous, active-low reset
//  start     in   1      request; accepted only when busy=0
//  op_a      in   OPW    operand A, sampled on accepting edge
//  op_b      in   OPW    operand B, sampled on accepting edge
//  cin_in    in   1      carry-in for nibble 0, sampled on accepting edge
//  busy      out  1      high in RUN and DONE
//  done      out  1      one-cycle pulse: result/cout/ovf valid
//  result    out  OPW    sum, held until next accepted start
//  cout      out  1      final carry-out (C[4] of last nibble)
//  ovf       out  1      signed overflow = C[4]^C[3] of last nibble
//  add_a     out  4      to adder A
//  add_b     out  4      to adder B
//  add_cin   out  1      to adder Cin
//  add_s     in   4      from adder S
//  add_c     in   4      from adder C[4:1] (bit-level carries; index 4 = carry-out)
// BEHAVIOUR
//  - One clock. Reset is asynchronous and active-low.
//  - Reset (async, any state, including mid-RUN): state=IDLE.
//    busy=0, done=0, result=0, cout=0, ovf=0, all internal regs=0.
//  - States: IDLE -> RUN (start && state==IDLE) -> DONE (after NIBBLES RUN cycles) -> IDLE (always, next edge).
//  - Accept edge E0: load a_sh=op_a, b_sh=op_b, carry=cin_in, idx=0, sum_sh=0.
//  - RUN, cycles E1..E(NIBBLES): add_a=a_sh[3:0], add_b=b_sh[3:0], add_cin=carry (combinational from regs).
//    On each edge: a_sh>>=4, b_sh>>=4, sum_sh={add_s,sum_sh[OPW-1:4]}, carry=add_c[4], idx++.
//    When idx==NIBBLES-1, also capture ovf=add_c[4]^add_c[3].
//  - Last RUN edge: result<=final sum, cout<=add_c[4], state->DONE.
//  - done=1 for exactly the DONE cycle, i.e. NIBBLES+1 edges after accept. busy stays 1 in DONE.
//  - Next start is accepted on the DONE->IDLE edge+1 at the earliest (IDLE required).
//  - In IDLE/DONE: add_a=0, add_b=0, add_cin=0.
//  - start while busy=1: ignored entirely, no queueing. Operand changes during RUN have no effect.
//  - result/cout/ovf change only on the last RUN edge or on reset. Previous values are held meanwhile.
//  - Arithmetic is unsigned modulo 2^OPW. cout is the unsigned carry; ovf is the two's-complement overflow.
//  - idx width = clog2(NIBBLES), minimum 1. NIBBLES=1 must work: one RUN cycle.
// STRUCTURE
//  - Package nibble_add_pkg: ADDER_W=4, state enum/localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
//  - Sub-module nibble_shreg: parallel-load, shift-right-by-4 register with async active-low clear.
//    Used for a_sh and b_sh; sum_sh shifts in at MSB, so add a direction parameter.
//  - The 4-bit adder is not instantiated here. The top level and bench wire it between add_* ports.
// TESTING (bench instantiates this block + the real 4-bit adder; NIBBLES=4)
//  1. 0x1234+0x4321, cin 0 -> result 0x5555, cout 0, ovf 0.
//     done exactly 5 edges after accept.
//  2. 0xFFFF+0x0001, cin 0 -> result 0x0000, cout 1, ovf 0.
//     Carry ripples across all nibbles.
//  3. 0x7FFF+0x0001, cin 0 -> result 0x8000, cout 0, ovf 1.
//     Then 0x8000+0x8000 -> 0x0000, cout 1, ovf 1.
//  4. 0x0000+0x0000, cin 1 -> result 0x0001.
//     Then 0xFFFF+0xFFFF, cin 1 -> 0xFFFF, cout 1.
//  5. start with new operands during RUN and during DONE -> ignored.
//     result equals the first operation; one done pulse only.
//  6. rst_n low at 2nd RUN cycle of 0xFFFF+0x0001 -> busy/done/result/cout/ovf=0 immediately.
//     After release, 0x0003+0x0004 -> 0x0007.

Source files
------------

// File: rtl/nibble_add_pkg.sv
// Shared types and constants for the nibble-serial add sequencer.
// Width of the external adder slice and the sequencer state encoding.
package nibble_add_pkg;

    localparam int ADDER_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_shreg.sv
// Parallel-load register shifting right one adder slice per step.
// FILL_MSB=1 enters fill_i at the top; otherwise zeros enter.
module nibble_shreg
    import nibble_add_pkg::*;
#(
    parameter int W        = 16,
    parameter bit FILL_MSB = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic [W-1:0]         load_val_i,
    input  logic                 shift_i,
    input  logic [ADDER_W-1:0]   fill_i,
    output logic [W-1:0]         q_o
);

    logic [W-1:0]       q_q;
    logic [W-1:0]       q_d;
    logic [ADDER_W-1:0] fill;

    assign fill = FILL_MSB ? fill_i : '0;

    generate
        if (W == ADDER_W) begin : g_single
            always_comb begin
                q_d = q_q;
                if (load_i) begin
                    q_d = load_val_i;
                end else if (shift_i) begin
                    q_d = fill;
                end
            end
        end else begin : g_multi
            always_comb begin
                q_d = q_q;
                if (load_i) begin
                    q_d = load_val_i;
                end else if (shift_i) begin
                    q_d = {fill, q_q[W-1:ADDER_W]};
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Drives an external 4-bit adder one nibble per cycle, LSB first,
// chaining carries and collecting the sum into a wide result.
module nibble_serial_add_ctrl
    import nibble_add_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [ADDER_W*NIBBLES-1:0] op_a,
    input  logic [ADDER_W*NIBBLES-1:0] op_b,
    input  logic                       cin_in,
    output logic                       busy,
    output logic                       done,
    output logic [ADDER_W*NIBBLES-1:0] result,
    output logic                       cout,
    output logic                       ovf,
    output logic [ADDER_W-1:0]         add_a,
    output logic [ADDER_W-1:0]         add_b,
    output logic                       add_cin,
    input  logic [ADDER_W-1:0]         add_s,
    input  logic [4:1]                 add_c
);

    localparam int OPW  = ADDER_W * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_e          state_q;
    logic [IDXW-1:0] idx_q;
    logic            carry_q;
    logic            busy_q;
    logic            done_q;
    logic [OPW-1:0]  result_q;
    logic            cout_q;
    logic            ovf_q;

    logic [OPW-1:0]  a_q;
    logic [OPW-1:0]  b_q;
    logic [OPW-1:0]  sum_q;
    logic [OPW-1:0]  sum_fin;

    logic accept;
    logic run;
    logic last;

    assign accept = start && (state_q == ST_IDLE);
    assign run    = (state_q == ST_RUN);
    assign last   = run && (idx_q == IDXW'(NIBBLES - 1));

    nibble_shreg #(.W(OPW), .FILL_MSB(1'b0)) u_a_sh (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept),
        .load_val_i (op_a),
        .shift_i    (run),
        .fill_i     ('0),
        .q_o        (a_q)
    );

    nibble_shreg #(.W(OPW), .FILL_MSB(1'b0)) u_b_sh (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept),
        .load_val_i (op_b),
        .shift_i    (run),
        .fill_i     ('0),
        .q_o        (b_q)
    );

    nibble_shreg #(.W(OPW), .FILL_MSB(1'b1)) u_sum_sh (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept),
        .load_val_i ('0),
        .shift_i    (run),
        .fill_i     (add_s),
        .q_o        (sum_q)
    );

    // The final nibble is still on add_s, so assemble it ahead of the shift.
    generate
        if (NIBBLES == 1) begin : g_fin_single
            assign sum_fin = add_s;
        end else begin : g_fin_multi
            assign sum_fin = {add_s, sum_q[OPW-1:ADDER_W]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                        carry_q <= cin_in;
                        idx_q   <= '0;
                    end
                end
                ST_RUN: begin
                    carry_q <= add_c[4];
                    idx_q   <= idx_q + 1'b1;
                    if (last) begin
                        state_q  <= ST_DONE;
                        done_q   <= 1'b1;
                        result_q <= sum_fin;
                        cout_q   <= add_c[4];
                        ovf_q    <= add_c[4] ^ add_c[3];
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{a_q, b_q, add_c[2:1]};

    assign add_a   = run ? a_q[ADDER_W-1:0] : '0;
    assign add_b   = run ? b_q[ADDER_W-1:0] : '0;
    assign add_cin = run ? carry_q : 1'b0;

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule
